tlul_adapter_reg: RTL



---
 rtl/tlul_pkg.sv | 53 +++++
 rtl/tlul_req_chk.sv | 29 ++
 rtl/tlul_adapter_reg.sv | 127 ++++++++++++
 3 files changed

// File: rtl/tlul_pkg.sv
// TL-UL link types, widths and opcodes shared by the register adapter and its request checker.
package tlul_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_SZW = 2;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic                a_valid;
    tl_a_op_e            a_opcode;
    logic [2:0]          a_param;
    logic [TL_SZW-1:0]   a_size;
    logic [TL_AIW-1:0]   a_source;
    logic [TL_AW-1:0]    a_address;
    logic [TL_DBW-1:0]   a_mask;
    logic [TL_DW-1:0]    a_data;
    logic                d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                d_valid;
    tl_d_op_e            d_opcode;
    logic [2:0]          d_param;
    logic [TL_SZW-1:0]   d_size;
    logic [TL_AIW-1:0]   d_source;
    logic                d_sink;
    logic [TL_DW-1:0]    d_data;
    logic                d_error;
    logic                a_ready;
  } tl_d2h_t;

  function automatic logic is_put_op(tl_a_op_e op);
    return (op == PutFullData) || (op == PutPartialData);
  endfunction

  function automatic logic is_get_op(tl_a_op_e op);
    return op == Get;
  endfunction

endpackage

// File: rtl/tlul_req_chk.sv
// Combinational A-channel legality check: opcode, alignment, size and mask; zero latency, no flow control.
module tlul_req_chk
  import tlul_pkg::*;
(
  input  tl_a_op_e            opcode,
  input  logic [1:0]          addr_lsb,
  input  logic [TL_SZW-1:0]   size,
  input  logic [TL_DBW-1:0]   mask,
  output logic                err
);

  logic known_op;
  logic bad_op;
  logic bad_align;
  logic bad_size;
  logic bad_full_mask;
  logic empty_mask;

  assign known_op      = is_get_op(opcode) || is_put_op(opcode);
  assign bad_op        = !known_op;
  assign bad_align     = addr_lsb != 2'b00;
  // Registers are word-wide; anything above a 4-byte beat cannot be served.
  assign bad_size      = size > TL_SZW'(2);
  assign bad_full_mask = (opcode == PutFullData) && (mask != {TL_DBW{1'b1}});
  assign empty_mask    = known_op && (mask == '0);

  assign err = bad_op | bad_align | bad_size | bad_full_mask | empty_mask;

endmodule

// File: rtl/tlul_adapter_reg.sv
// TL-UL device responder to register strobes: strobes on accept, response 1 cycle later, held under d_ready backpressure.
// Request legality checking is built in only when TLUL_ADAPTER_REG_ERR_CHECK_EN is defined.
module tlul_adapter_reg
  import tlul_pkg::*;
#(
  parameter int RegAw = 8,
  parameter int RegDw = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  tl_h2d_t            tl_i,
  output tl_d2h_t            tl_o,
  output logic               re_o,
  output logic               we_o,
  output logic [RegAw-1:0]   addr_o,
  output logic [RegDw-1:0]   wdata_o,
  output logic [RegDw/8-1:0] be_o,
  input  logic [RegDw-1:0]   rdata_i,
  input  logic               error_i
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  state_e             state;
  state_e             state_nxt;
  logic               accept;
  logic               req_err;
  logic               is_get;
  logic               is_put;
  logic               cap_err;

  logic [TL_AIW-1:0]  rsp_source;
  logic [TL_SZW-1:0]  rsp_size;
  tl_d_op_e           rsp_op;
  logic [RegDw-1:0]   rsp_data;
  logic               rsp_err;

  assign is_get = is_get_op(tl_i.a_opcode);
  assign is_put = is_put_op(tl_i.a_opcode);

`ifdef TLUL_ADAPTER_REG_ERR_CHECK_EN
  tlul_req_chk u_req_chk (
    .opcode   (tl_i.a_opcode),
    .addr_lsb (tl_i.a_address[1:0]),
    .size     (tl_i.a_size),
    .mask     (tl_i.a_mask),
    .err      (req_err)
  );
`else
  assign req_err = 1'b0;
`endif

  assign cap_err = req_err | error_i;

  // Register-side fields are straight pass-through; only the strobes qualify them.
  assign addr_o  = {tl_i.a_address[RegAw-1:2], 2'b00};
  assign wdata_o = tl_i.a_data;
  assign be_o    = tl_i.a_mask;

  logic unused_tl;
  assign unused_tl = ^{tl_i.a_param, tl_i.a_address[TL_AW-1:RegAw], tl_i.a_address[1:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    re_o      = 1'b0;
    we_o      = 1'b0;
    unique case (state)
      IDLE: begin
        if (tl_i.a_valid) begin
          accept    = 1'b1;
          re_o      = is_get && !req_err;
          we_o      = is_put && !req_err;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (tl_i.d_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Response fields load only on accept, so they stay frozen through any D stall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_source <= '0;
      rsp_size   <= '0;
      rsp_op     <= AccessAck;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else if (accept) begin
      rsp_source <= tl_i.a_source;
      rsp_size   <= tl_i.a_size;
      rsp_op     <= is_get ? AccessAckData : AccessAck;
      rsp_err    <= cap_err;
      rsp_data   <= (is_get && !cap_err) ? rdata_i : '0;
    end
  end

  always_comb begin
    tl_o          = '0;
    tl_o.a_ready  = (state == IDLE);
    tl_o.d_valid  = (state == RESP);
    tl_o.d_opcode = rsp_op;
    tl_o.d_param  = 3'b000;
    tl_o.d_size   = rsp_size;
    tl_o.d_source = rsp_source;
    tl_o.d_sink   = 1'b0;
    tl_o.d_data   = rsp_data;
    tl_o.d_error  = rsp_err;
  end

endmodule
